// File: rtl/sens_window.sv
// Crops a programmable window out of the pad-stage pixel stream and emits framed strobes.
// Latency 1 clk for every output; no backpressure, pixels arrive at line rate.
module sens_window #(
  parameter int DW = 16,
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vacts,
  input  logic          ihact,
  input  logic [DW-1:0] ipxd,
  input  logic [CW-1:0] win_left,
  input  logic [CW-1:0] win_width,
  input  logic [CW-1:0] win_top,
  input  logic [CW-1:0] win_height,
  input  logic          err_clr,
  output logic          frame_start,
  output logic          line_start,
  output logic          line_end,
  output logic          dv,
  output logic [DW-1:0] dout,
  output logic          frame_done,
  output logic          busy,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_lines,
  output logic          err_short,
  output logic          err_abort
);

  typedef enum logic [1:0] {IDLE, PRE, WIN, POST} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_hact_d;
  logic          r_skip;
  logic          r_line_open;
  logic [CW-1:0] r_pix_cnt;
  logic [CW-1:0] r_line_cnt;
  logic [CW-1:0] r_left;
  logic [CW-1:0] r_width;
  logic [CW-1:0] r_top;
  logic [CW-1:0] r_height;

  logic          w_active;
  logic          w_restart;
  logic          w_act;
  logic          w_rise;
  logic          w_fall;
  logic          w_enter;
  logic          w_in_win;
  logic          w_dv;
  logic          w_ls;
  logic          w_fs;
  logic          w_le;
  logic          w_short;
  logic          w_fd;
  logic          w_abort;
  logic [CW-1:0] w_col;
  logic [CW-1:0] w_col_inc;
  logic [CW-1:0] w_line_inc;
  logic [CW-1:0] w_meas_w;
  logic [CW:0]   w_right;
  logic [CW:0]   w_bottom;

  // One extra bit so an out-of-range window edge is simply never reached.
  assign w_right  = {1'b0, r_left} + {1'b0, r_width};
  assign w_bottom = {1'b0, r_top} + {1'b0, r_height};

  always_comb begin
    w_active   = (r_state != IDLE);
    w_restart  = vacts & (w_active | en);
    // r_skip masks a line that was already running when the frame restarted.
    w_act      = w_active & ihact & ~r_skip;
    w_rise     = w_act & ~r_hact_d;
    w_fall     = w_active & ~ihact & r_hact_d & ~r_skip;
    w_col      = w_rise ? '0 : r_pix_cnt;
    w_col_inc  = (w_col == '1) ? w_col : w_col + CW'(1);
    w_line_inc = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + CW'(1);
    w_meas_w   = (r_pix_cnt == '0) ? '0 : r_pix_cnt - CW'(1);
    w_enter    = (r_state == PRE) & w_rise & (r_line_cnt == r_top);
    w_in_win   = (r_state == WIN) | w_enter;
    w_dv       = ~vacts & w_act & w_in_win & (w_col >= r_left) & ({1'b0, w_col} <= w_right);
    w_ls       = w_dv & (w_col == r_left);
    w_fs       = w_ls & (r_line_cnt == r_top);
    w_short    = (r_state == WIN) & w_fall & r_line_open;
    w_le       = (w_dv & ({1'b0, w_col} == w_right)) | w_short;
    w_fd       = (r_state == WIN) & w_fall & ({1'b0, r_line_cnt} == w_bottom);
    w_abort    = vacts & w_active & (ihact | (r_line_open & ~w_fall));

    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (vacts && en) w_state_nxt = PRE;
      PRE:     if (w_enter)     w_state_nxt = WIN;
      WIN:     if (w_fd)        w_state_nxt = POST;
      default: w_state_nxt = r_state;
    endcase
    if (w_active && vacts) w_state_nxt = en ? PRE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hact_d    <= 1'b0;
      r_skip      <= 1'b0;
      r_line_open <= 1'b0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_left      <= '0;
      r_width     <= '0;
      r_top       <= '0;
      r_height    <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      dv          <= 1'b0;
      dout        <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      meas_width  <= '0;
      meas_lines  <= '0;
      err_short   <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hact_d    <= ihact;
      frame_start <= w_fs;
      line_start  <= w_ls;
      line_end    <= w_le;
      dv          <= w_dv;
      dout        <= ipxd;
      frame_done  <= w_fd;
      busy        <= (w_state_nxt != IDLE);

      if (w_fall) meas_width <= w_meas_w;

      if (w_restart)   r_skip <= ihact;
      else if (!ihact) r_skip <= 1'b0;

      if (vacts || w_le) r_line_open <= 1'b0;
      else if (w_ls)     r_line_open <= 1'b1;

      // A line closing in the restart cycle is still counted into meas_lines.
      if (w_restart) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_left     <= win_left;
        r_width    <= win_width;
        r_top      <= win_top;
        r_height   <= win_height;
        if (w_active) meas_lines <= w_fall ? w_line_inc : r_line_cnt;
      end else if (w_active) begin
        if (w_act)  r_pix_cnt  <= w_col_inc;
        if (w_fall) r_line_cnt <= w_line_inc;
      end

      if (w_short)      err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;

      if (w_abort)      err_abort <= 1'b1;
      else if (err_clr) err_abort <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sens_window.sv
// Directed bench for sens_window: per-cycle expected strobes are queued as stimulus is driven
// and popped one clock later when the registered outputs appear.
module tb_sens_window;

  localparam int DW = 16;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          rst, en, vacts, ihact, err_clr;
  logic [DW-1:0] ipxd;
  logic [CW-1:0] win_left, win_width, win_top, win_height;
  logic          frame_start, line_start, line_end, dv, frame_done, busy;
  logic [DW-1:0] dout;
  logic [CW-1:0] meas_width, meas_lines;
  logic          err_short, err_abort;

  sens_window #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .vacts(vacts), .ihact(ihact), .ipxd(ipxd),
    .win_left(win_left), .win_width(win_width), .win_top(win_top), .win_height(win_height),
    .err_clr(err_clr), .frame_start(frame_start), .line_start(line_start),
    .line_end(line_end), .dv(dv), .dout(dout), .frame_done(frame_done), .busy(busy),
    .meas_width(meas_width), .meas_lines(meas_lines), .err_short(err_short),
    .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          dv;
    logic [DW-1:0] dout;
    logic          ls, le, fs, fd, busy;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic b_exp    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic [DW-1:0] px,
                              input logic ls, input logic le, input logic fs, input logic fd);
    exp_t e;
    e.dv = d; e.dout = px; e.ls = ls; e.le = le; e.fs = fs; e.fd = fd; e.busy = b_exp;
    return e;
  endfunction

  // Drive one input cycle, then compare the registered response one clock later.
  task automatic cyc(input logic v, input logic h, input logic [DW-1:0] px, input exp_t e);
    exp_t x;
    vacts = v; ihact = h; ipxd = px;
    q.push_back(e);
    @(posedge clk); #1;
    x = q.pop_front();
    chk("dv", 32'(dv), 32'(x.dv));
    chk("dout", 32'(dout), 32'(x.dout));
    chk("line_start", 32'(line_start), 32'(x.ls));
    chk("line_end", 32'(line_end), 32'(x.le));
    chk("frame_start", 32'(frame_start), 32'(x.fs));
    chk("frame_done", 32'(frame_done), 32'(x.fd));
    chk("busy", 32'(busy), 32'(x.busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, mk(0, '0, 0, 0, 0, 0));
  endtask

  task automatic vact(input logic h);
    cyc(1'b1, h, 16'h0BAD, mk(0, 16'h0BAD, 0, 0, 0, 0));
  endtask

  // Full line: window columns L..R are expected only when the line lies inside the window.
  task automatic send_line(input int lno, input int npix, input int L, input int R,
                           input bit inw, input bit first, input bit last);
    logic [DW-1:0] px;
    bit d, shrt;
    for (int c = 0; c < npix; c++) begin
      px = DW'(lno * 16 + c);
      d  = inw && c >= L && c <= R;
      cyc(1'b0, 1'b1, px, mk(d, px, d && c == L, d && c == R, d && c == L && first, 0));
    end
    shrt = inw && (npix - 1) >= L && (npix - 1) < R;
    cyc(1'b0, 1'b0, 16'hFFFF, mk(0, 16'hFFFF, 0, shrt, 0, inw && last));
    idle(2);
  endtask

  initial begin
    logic [DW-1:0] px;
    rst = 1'b1; en = 1'b1; vacts = 1'b0; ihact = 1'b0; ipxd = '0; err_clr = 1'b0;
    win_left = 14'd2; win_width = 14'd3; win_top = 14'd1; win_height = 14'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", 32'(dv), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_ls", 32'(line_start), 0);
    chk("rst_le", 32'(line_end), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_meas_width", 32'(meas_width), 0);
    chk("rst_meas_lines", 32'(meas_lines), 0);
    chk("rst_err_short", 32'(err_short), 0);
    chk("rst_err_abort", 32'(err_abort), 0);
    rst = 1'b0;
    idle(2);

    // Basic crop: window lines 1-2, columns 2..5.
    b_exp = 1'b1;
    vact(1'b0);
    for (int l = 0; l < 4; l++) send_line(l, 10, 2, 5, l == 1 || l == 2, l == 1, l == 2);
    chk("meas_width_10px", 32'(meas_width), 9);

    // Short line: window wider than the line.
    win_width = 14'd7; win_top = 14'd0; win_height = 14'd0;
    vact(1'b0);
    chk("meas_lines_frame1", 32'(meas_lines), 4);
    send_line(0, 6, 2, 9, 1, 1, 1);
    chk("meas_width_6px", 32'(meas_width), 5);
    chk("err_short_set", 32'(err_short), 1);
    idle(2);
    chk("err_short_sticky", 32'(err_short), 1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_short_clr", 32'(err_short), 0);

    // Frame restart in the middle of a window line.
    win_width = 14'd3; win_top = 14'd0; win_height = 14'd1;
    vact(1'b0);
    chk("meas_lines_frame2", 32'(meas_lines), 1);
    for (int c = 0; c < 4; c++) begin
      px = DW'(c);
      cyc(1'b0, 1'b1, px, mk(c >= 2, px, c == 2, 0, c == 2, 0));
    end
    vact(1'b1);
    cyc(1'b0, 1'b1, 16'h0004, mk(0, 16'h0004, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, 16'h0005, mk(0, 16'h0005, 0, 0, 0, 0));
    idle(2);
    chk("err_abort_set", 32'(err_abort), 1);
    chk("meas_width_abort", 32'(meas_width), 5);
    chk("meas_lines_abort", 32'(meas_lines), 0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_abort_clr", 32'(err_abort), 0);
    send_line(0, 8, 2, 5, 1, 1, 0);
    // Mid-frame window change must not affect the current frame.
    win_left = 14'd0;
    send_line(1, 8, 2, 5, 1, 0, 1);
    vact(1'b0);
    chk("meas_lines_frame3", 32'(meas_lines), 2);
    send_line(0, 8, 0, 3, 1, 1, 0);
    send_line(1, 8, 0, 3, 1, 0, 1);
    chk("meas_width_8px", 32'(meas_width), 7);

    // Disabled frame start.
    en = 1'b0; b_exp = 1'b0;
    vact(1'b0);
    chk("meas_lines_en0", 32'(meas_lines), 2);
    send_line(0, 10, 0, 3, 0, 0, 0);
    vact(1'b0);
    send_line(1, 10, 0, 3, 0, 0, 0);
    chk("meas_width_idle", 32'(meas_width), 7);
    chk("meas_lines_idle", 32'(meas_lines), 2);
    en = 1'b1; b_exp = 1'b1;
    vact(1'b0);
    send_line(0, 5, 0, 3, 1, 1, 0);
    chk("meas_width_resume", 32'(meas_width), 4);
    send_line(1, 8, 0, 3, 1, 0, 1);

    // vacts coincident with an ihact fall in POST.
    for (int c = 0; c < 6; c++) begin
      px = DW'(16'h0020 + c);
      cyc(1'b0, 1'b1, px, mk(0, px, 0, 0, 0, 0));
    end
    vact(1'b0);
    chk("meas_width_coinc", 32'(meas_width), 5);
    chk("meas_lines_coinc", 32'(meas_lines), 3);
    chk("err_abort_coinc", 32'(err_abort), 0);
    idle(1);
    send_line(0, 8, 0, 3, 1, 1, 0);

    // Reset in the middle of a window line.
    for (int c = 0; c < 3; c++) begin
      px = DW'(16 + c);
      cyc(1'b0, 1'b1, px, mk(1, px, c == 0, 0, 0, 0));
    end
    rst = 1'b1; b_exp = 1'b0;
    cyc(1'b0, 1'b1, 16'h0013, mk(0, '0, 0, 0, 0, 0));
    rst = 1'b0;
    chk("rst_mid_meas_width", 32'(meas_width), 0);
    chk("rst_mid_meas_lines", 32'(meas_lines), 0);
    chk("rst_mid_err_short", 32'(err_short), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
